// File: rtl/uart_autobaud_ctrl.sv
// Auto-baud controller: times a host 0x55 sync character on Rx and derives the
// 16x-oversampling divider for the baud-rate generator.
module uart_autobaud_ctrl #(
   parameter int DEFAULT_DIV = 325,
   parameter int MIN_DIV     = 4,
   parameter int IDLE_CLKS   = 16,
   parameter int MAX_SEG     = 1048575
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Rx,
   input  logic        Start,
   output logic [15:0] BaudRate,
   output logic        Busy,
   output logic        Locked,
   output logic        Done,
   output logic        Error
);

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_ARM        = 3'd1;
   localparam logic [2:0] ST_WAIT_START = 3'd2;
   localparam logic [2:0] ST_MEASURE    = 3'd3;
   localparam logic [2:0] ST_WAIT_STOP  = 3'd4;
   localparam logic [2:0] ST_CALC       = 3'd5;
   localparam logic [2:0] ST_ERR        = 3'd6;

   // One spare bit so a segment can run up to 1.5x a MAX_SEG-long start bit
   localparam int CNT_W = $clog2(MAX_SEG + 1) + 1;
   localparam int RUN_W = $clog2(IDLE_CLKS + 1);

   logic [2:0]       state;
   logic             rx_m, rx_s, rx_d;
   logic [RUN_W-1:0] run_cnt;
   logic [CNT_W-1:0] seg;
   logic [CNT_W-1:0] seg0;
   logic [23:0]      tot;
   logic [23:0]      t8;
   logic [3:0]       edge_idx;

   logic             rx_edge, rx_fall;
   logic [CNT_W-1:0] seg_len;
   logic [CNT_W-1:0] win_lo;
   logic [CNT_W:0]   win_hi;
   logic             in_window, above_window, seg_max;
   logic [17:0]      div;
   logic             div_ok;

   assign rx_edge = rx_s ^ rx_d;
   assign rx_fall = rx_d & ~rx_s;

   // Widths count the edge cycle itself, so a segment of W clocks measures W
   assign seg_len      = seg + CNT_W'(1);
   assign win_lo       = seg0 >> 1;
   assign win_hi       = {1'b0, seg0} + {2'b00, seg0[CNT_W-1:1]};
   assign in_window    = (seg_len >= win_lo) && ({1'b0, seg_len} <= win_hi);
   assign above_window = {1'b0, seg_len} > win_hi;
   assign seg_max      = (seg == CNT_W'(MAX_SEG));

   assign div    = 18'(({1'b0, t8} + 25'd64) >> 7);
   assign div_ok = (div >= 18'(MIN_DIV)) && (div <= 18'd65535);

   assign Busy = (state != ST_IDLE);

   always_ff @(posedge Clk) begin
      if (Rst) begin
         rx_m     <= 1'b1;
         rx_s     <= 1'b1;
         rx_d     <= 1'b1;
         state    <= ST_IDLE;
         run_cnt  <= '0;
         seg      <= '0;
         seg0     <= '0;
         tot      <= '0;
         t8       <= '0;
         edge_idx <= '0;
         BaudRate <= 16'(DEFAULT_DIV);
         Locked   <= 1'b0;
         Done     <= 1'b0;
         Error    <= 1'b0;
      end else begin
         rx_m <= Rx;
         rx_s <= rx_m;
         rx_d <= rx_s;
         Done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (Start) begin
                  Error   <= 1'b0;
                  Locked  <= 1'b0;
                  run_cnt <= '0;
                  state   <= ST_ARM;
               end
            end
            ST_ARM: begin
               if (!rx_s)
                  run_cnt <= '0;
               else if (run_cnt == RUN_W'(IDLE_CLKS - 1))
                  state <= ST_WAIT_START;
               else
                  run_cnt <= run_cnt + RUN_W'(1);
            end
            ST_WAIT_START: begin
               if (rx_fall) begin
                  seg      <= '0;
                  tot      <= '0;
                  edge_idx <= '0;
                  state    <= ST_MEASURE;
               end
            end
            ST_MEASURE: begin
               seg <= seg + CNT_W'(1);
               tot <= tot + 24'd1;
               if (rx_edge) begin
                  seg      <= '0;
                  edge_idx <= edge_idx + 4'd1;
                  if (edge_idx == 4'd0)
                     seg0 <= seg_len;
                  else if (!in_window)
                     state <= ST_ERR;
                  else if (edge_idx == 4'd7) begin
                     t8    <= tot + 24'd1;
                     state <= ST_WAIT_STOP;
                  end
               end else if (edge_idx == 4'd0) begin
                  if (seg_max)
                     state <= ST_ERR;
               end else if (above_window) begin
                  state <= ST_ERR;
               end
            end
            ST_WAIT_STOP: begin
               seg <= seg + CNT_W'(1);
               if (rx_edge)
                  state <= in_window ? ST_CALC : ST_ERR;
               else if (above_window)
                  state <= ST_ERR;
            end
            ST_CALC: begin
               if (div_ok) begin
                  BaudRate <= div[15:0];
                  Locked   <= 1'b1;
                  Done     <= 1'b1;
                  state    <= ST_IDLE;
               end else begin
                  state <= ST_ERR;
               end
            end
            ST_ERR: begin
               Error <= 1'b1;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Self-checking bench for uart_autobaud_ctrl: directed and randomized sync
// frames compared against a frame-level model of the divider computation.
module tb_uart_autobaud_ctrl;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        Rx;
   logic        Start;
   logic [15:0] BaudRate;
   logic        Busy, Locked, Done, Error;

   int   total = 0;
   int   bad   = 0;
   int   segW[9];
   int   doneCnt = 0;
   logic prevBusy = 1'b0;
   logic busyAtDone = 1'b0;
   logic prevBusyAtDone = 1'b0;
   int   expBaud;
   int   expLocked;
   int   expError;

   uart_autobaud_ctrl dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .Rx       (Rx),
      .Start    (Start),
      .BaudRate (BaudRate),
      .Busy     (Busy),
      .Locked   (Locked),
      .Done     (Done),
      .Error    (Error)
   );

   always #5 Clk = ~Clk;

   // Track Done pulses and the Busy level around them
   always @(negedge Clk) begin
      if (Done) begin
         doneCnt++;
         busyAtDone = Busy;
         prevBusyAtDone = prevBusy;
      end
      prevBusy = Busy;
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Frame-level reference: start bit sets the window, T8 is the sum of the first eight segments
   function automatic void modelFrame(output bit ok, output int div);
      int w0;
      int t8;
      w0 = segW[0];
      t8 = 0;
      ok = 1'b1;
      if (w0 >= 1048575) ok = 1'b0;
      for (int k = 1; k < 9; k++)
         if (segW[k] < w0 / 2 || segW[k] > w0 + w0 / 2) ok = 1'b0;
      for (int k = 0; k < 8; k++) t8 += segW[k];
      div = (t8 + 64) / 128;
      if (div < 4 || div > 65535) ok = 1'b0;
   endfunction

   task automatic setUniform(input int w);
      for (int k = 0; k < 9; k++) segW[k] = w;
   endtask

   task automatic pulseStart();
      @(negedge Clk) Start = 1'b1;
      @(negedge Clk) Start = 1'b0;
   endtask

   task automatic applyStimulus(input int midStart);
      for (int k = 0; k < 9; k++) begin
         Rx = k[0];
         for (int c = 0; c < segW[k]; c++) begin
            Start = (k == midStart && c == 0);
            @(negedge Clk);
         end
      end
      Start = 1'b0;
      Rx = 1'b1;
      repeat (20) @(negedge Clk);
      for (int i = 0; i < 1000 && Busy; i++) @(negedge Clk);
   endtask

   task automatic runFrame(input string name, input int midStart);
      bit ok;
      int div;
      int d0;
      modelFrame(ok, div);
      d0 = doneCnt;
      pulseStart();
      expError = 0;
      expLocked = 0;
      repeat (100) @(negedge Clk);
      applyStimulus(midStart);
      if (ok) begin
         expBaud = div;
         expLocked = 1;
      end else begin
         expError = 1;
      end
      checkOutput({name, ".baud"}, int'(BaudRate), expBaud);
      checkOutput({name, ".locked"}, int'(Locked), expLocked);
      checkOutput({name, ".error"}, int'(Error), expError);
      checkOutput({name, ".busy"}, int'(Busy), 0);
      checkOutput({name, ".dones"}, doneCnt - d0, ok ? 1 : 0);
      if (ok) begin
         checkOutput({name, ".busyAtDone"}, int'(busyAtDone), 0);
         checkOutput({name, ".busyBeforeDone"}, int'(prevBusyAtDone), 1);
      end
   endtask

   initial begin
      int w;
      Rst = 1'b1;
      Rx = 1'b1;
      Start = 1'b0;
      expBaud = 325;
      expLocked = 0;
      expError = 0;
      repeat (3) @(negedge Clk);
      Rst = 1'b0;
      @(negedge Clk);
      checkOutput("reset.baud", int'(BaudRate), 325);
      checkOutput("reset.locked", int'(Locked), 0);
      checkOutput("reset.busy", int'(Busy), 0);
      checkOutput("reset.error", int'(Error), 0);
      checkOutput("reset.done", int'(Done), 0);

      setUniform(5208);
      runFrame("b9600", -1);
      checkOutput("b9600.const", int'(BaudRate), 326);

      setUniform(434);
      runFrame("b115200", -1);
      checkOutput("b115200.const", int'(BaudRate), 27);

      setUniform(868);
      segW[3] = 300;
      runFrame("shortBit", -1);
      checkOutput("shortBit.keep", int'(BaudRate), 27);

      setUniform(40);
      runFrame("tooFast", -1);
      checkOutput("tooFast.keep", int'(BaudRate), 27);

      setUniform(56);
      runFrame("minDiv", -1);
      checkOutput("minDiv.const", int'(BaudRate), 4);

      setUniform(55);
      runFrame("belowMin", -1);
      checkOutput("belowMin.keep", int'(BaudRate), 4);

      setUniform(434);
      runFrame("relock", -1);

      // Abort mid-measurement after the fourth edge
      pulseStart();
      repeat (100) @(negedge Clk);
      for (int k = 0; k < 4; k++) begin
         Rx = k[0];
         repeat (434) @(negedge Clk);
      end
      Rx = 1'b0;
      repeat (100) @(negedge Clk);
      checkOutput("abort.busyBefore", int'(Busy), 1);
      Rx = 1'b1;
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      checkOutput("abort.baud", int'(BaudRate), 325);
      checkOutput("abort.locked", int'(Locked), 0);
      checkOutput("abort.busy", int'(Busy), 0);
      checkOutput("abort.error", int'(Error), 0);
      expBaud = 325;
      repeat (5) @(negedge Clk);

      setUniform(434);
      runFrame("startWhileBusy", 4);

      for (int n = 0; n < 6; n++) begin
         w = $urandom_range(40, 160);
         for (int k = 0; k < 9; k++) segW[k] = w - w / 10 + $urandom_range(0, w / 5);
         if ($urandom_range(0, 2) == 0) segW[$urandom_range(1, 8)] = w / 3;
         runFrame($sformatf("rand%0d", n), -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
